picport_gen: RTL and testbench

Parametrised general-purpose I/O port for the PIC16F8x-compatible core, replacing the fixed 5-bit PORTA and 8-bit PORTB wiring with one reusable block instantiated per port. It holds the PORT output latch and TRIS direction register, and synchronises pad inputs. It also generates the two port-related interrupt flags: interrupt-on-change (RBIF-style) and edge-triggered external interrupt (INTF-style). The block sits between the core's special-function-register bus and the pads.

---
 rtl/picport_gen.sv | 94 +++++++++
 tb/tb_picport_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/picport_gen.sv
// General-purpose I/O port: output latch, direction register, pad synchroniser,
// interrupt-on-change and edge-triggered external interrupt flags.
module picport_gen #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  IOC_MASK    = WIDTH'(8'hF0),
    parameter int                INT_BIT     = 0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic             clkin,
    input  logic             ponrst,
    input  logic             regsel,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_dir,
    input  logic             intedg,
    output logic             ioc_flag,
    input  logic             ioc_clr,
    output logic             int_flag,
    input  logic             int_clr,
    output logic             wake
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] pin_out_q, pin_out_d;
    logic [WIDTH-1:0] pin_dir_q, pin_dir_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             prev_q;
    logic             ioc_flag_q, ioc_flag_d;
    logic             int_flag_q, int_flag_d;
    logic             wake_q;
    logic             mismatch;
    logic             edge_det;

    assign sync = sync_q[SYNC_STAGES-1];

    // Pad synchroniser
    always_ff @(posedge clkin) begin
        if (ponrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Only input-configured, IOC-enabled pins can raise a change mismatch.
    assign mismatch = |(IOC_MASK & pin_dir_q & (sync ^ snap_q));
    assign edge_det = intedg ? (~prev_q & sync[INT_BIT]) : (prev_q & ~sync[INT_BIT]);

    always_comb begin
        pin_out_d  = pin_out_q;
        pin_dir_d  = pin_dir_q;
        snap_d     = snap_q;
        if (wr && !regsel) pin_out_d = wdata;
        if (wr && regsel)  pin_dir_d = wdata;
        if (rd && !regsel) snap_d    = sync & IOC_MASK;
        // A set in the same cycle as a clear wins so no event is dropped.
        ioc_flag_d = mismatch | (ioc_flag_q & ~ioc_clr);
        int_flag_d = edge_det | (int_flag_q & ~int_clr);
    end

    always_ff @(posedge clkin) begin
        if (ponrst) begin
            pin_out_q  <= '0;
            pin_dir_q  <= '1;
            snap_q     <= '0;
            prev_q     <= 1'b0;
            ioc_flag_q <= 1'b0;
            int_flag_q <= 1'b0;
            wake_q     <= 1'b0;
        end else begin
            pin_out_q  <= pin_out_d;
            pin_dir_q  <= pin_dir_d;
            snap_q     <= snap_d;
            prev_q     <= sync[INT_BIT];
            ioc_flag_q <= ioc_flag_d;
            int_flag_q <= int_flag_d;
            wake_q     <= ioc_flag_q | int_flag_q;
        end
    end

    assign rdata    = regsel ? pin_dir_q : ((pin_dir_q & sync) | (~pin_dir_q & pin_out_q));
    assign pin_out  = pin_out_q;
    assign pin_dir  = pin_dir_q;
    assign ioc_flag = ioc_flag_q;
    assign int_flag = int_flag_q;
    assign wake     = wake_q;

endmodule

// File: tb/tb_picport_gen.sv
// Directed bench for picport_gen: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_picport_gen;

    logic       clkin = 1'b0;
    logic       ponrst, regsel, wr, rd, intedg, ioc_clr, int_clr;
    logic [7:0] wdata, rdata, pin_in, pin_out, pin_dir;
    logic       ioc_flag, int_flag, wake;

    picport_gen dut (
        .clkin(clkin), .ponrst(ponrst), .regsel(regsel), .wr(wr), .rd(rd),
        .wdata(wdata), .rdata(rdata), .pin_in(pin_in), .pin_out(pin_out),
        .pin_dir(pin_dir), .intedg(intedg), .ioc_flag(ioc_flag), .ioc_clr(ioc_clr),
        .int_flag(int_flag), .int_clr(int_clr), .wake(wake)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %h with no queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic write_reg(input logic sel, input logic [7:0] d);
        regsel = sel; wr = 1'b1; wdata = d;
        tick();
        wr = 1'b0; regsel = 1'b0;
    endtask

    // Drive a pad value, let it propagate, then read PORT and clear both flags.
    task automatic settle(input logic [7:0] v);
        pin_in = v;
        tick(4);
        regsel = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0; ioc_clr = 1'b1; int_clr = 1'b1;
        tick();
        ioc_clr = 1'b0; int_clr = 1'b0;
        tick();
    endtask

    logic [7:0] m_out, m_dir, m_pins;

    initial begin
        ponrst = 1'b1; regsel = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
        pin_in = '0; intedg = 1'b1; ioc_clr = 1'b0; int_clr = 1'b0;

        // Reset then read
        push("rst_pin_out", 16'h0000);
        push("rst_pin_dir", 16'h00FF);
        push("rst_ioc", 16'h0);
        push("rst_int", 16'h0);
        push("rst_wake", 16'h0);
        push("rst_rd_tris", 16'h00FF);
        tick(2);
        ponrst = 1'b0;
        check(16'(pin_out));
        check(16'(pin_dir));
        check(16'(ioc_flag));
        check(16'(int_flag));
        check(16'(wake));
        regsel = 1'b1; #1;
        check(16'(rdata));
        pin_in = 8'hA5;
        push("rd_port_a5", 16'h00A5);
        tick(2);
        regsel = 1'b0; #1;
        check(16'(rdata));
        settle(8'hA5);

        // Latch vs. direction
        m_out = 8'h3C; m_dir = 8'h0F; m_pins = 8'hFF;
        write_reg(1'b0, m_out);
        write_reg(1'b1, m_dir);
        push("lat_pin_out", 16'(m_out));
        push("lat_pin_dir", 16'(m_dir));
        push("lat_rd_port", 16'((m_dir & m_pins) | (~m_dir & m_out)));
        push("lat_ioc", 16'h0);
        settle(m_pins);
        check(16'(pin_out));
        check(16'(pin_dir));
        regsel = 1'b0; #1;
        check(16'(rdata));
        check(16'(ioc_flag));

        // Interrupt-on-change
        write_reg(1'b1, 8'hFF);
        settle(8'h00);
        push("ioc_idle", 16'h0);
        check(16'(ioc_flag));
        pin_in = 8'h20;
        push("ioc_pre", 16'h0);
        push("ioc_at3", 16'h1);
        tick(2); check(16'(ioc_flag));
        tick();  check(16'(ioc_flag));
        push("ioc_clr_noread", 16'h1);
        ioc_clr = 1'b1; tick(); ioc_clr = 1'b0;
        check(16'(ioc_flag));
        push("ioc_read_clr", 16'h0);
        push("ioc_stays0", 16'h0);
        rd = 1'b1; tick(); rd = 1'b0;
        ioc_clr = 1'b1; tick(); ioc_clr = 1'b0;
        check(16'(ioc_flag));
        tick(2); check(16'(ioc_flag));
        pin_in = 8'h24;
        push("ioc_unmasked_pin2", 16'h0);
        tick(4); check(16'(ioc_flag));

        // Edge interrupt
        intedg = 1'b1;
        pin_in = 8'h25;
        push("int_rise_pre", 16'h0);
        push("int_rise_at3", 16'h1);
        push("wake_at3", 16'h0);
        push("wake_at4", 16'h1);
        push("ioc_pin0_unmasked", 16'h0);
        tick(2); check(16'(int_flag));
        tick();  check(16'(int_flag)); check(16'(wake));
        tick();  check(16'(wake)); check(16'(ioc_flag));
        push("int_clr", 16'h0);
        int_clr = 1'b1; tick(); int_clr = 1'b0;
        check(16'(int_flag));
        pin_in = 8'h24;
        push("int_fall_rising_sel", 16'h0);
        tick(4); check(16'(int_flag));
        intedg = 1'b0;
        push("int_edgesel_change", 16'h0);
        tick(); check(16'(int_flag));
        pin_in = 8'h25;
        push("int_rise_falling_sel", 16'h0);
        tick(4); check(16'(int_flag));
        pin_in = 8'h24;
        push("int_fall_pre", 16'h0);
        push("int_fall_at3", 16'h1);
        tick(2); check(16'(int_flag));
        tick();  check(16'(int_flag));
        int_clr = 1'b1; tick(); int_clr = 1'b0;
        tick();

        // Simultaneous set and clear
        intedg = 1'b1;
        int_clr = 1'b1;
        pin_in = 8'h25;
        push("setclr_at3", 16'h1);
        push("setclr_after", 16'h0);
        tick(3); check(16'(int_flag));
        tick();  check(16'(int_flag));
        int_clr = 1'b0;
        pin_in = 8'h24;
        tick(4);

        // Reset mid-run
        write_reg(1'b0, 8'h55);
        pin_in = 8'h35;
        push("mid_pin_out", 16'h0055);
        push("mid_ioc_set", 16'h1);
        push("mid_int_set", 16'h1);
        tick(4);
        check(16'(pin_out)); check(16'(ioc_flag)); check(16'(int_flag));
        push("mrst_pin_out", 16'h0);
        push("mrst_pin_dir", 16'h00FF);
        push("mrst_ioc", 16'h0);
        push("mrst_int", 16'h0);
        push("mrst_wake", 16'h0);
        ponrst = 1'b1; wr = 1'b1; regsel = 1'b0; wdata = 8'hAA;
        tick();
        ponrst = 1'b0; wr = 1'b0;
        check(16'(pin_out)); check(16'(pin_dir));
        check(16'(ioc_flag)); check(16'(int_flag)); check(16'(wake));
        push("post_rst_int_pre", 16'h0);
        push("post_rst_int_edge", 16'h1);
        push("post_rst_ioc", 16'h1);
        tick(2); check(16'(int_flag));
        tick();  check(16'(int_flag)); check(16'(ioc_flag));

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_leftover: observed %0d entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
